mem_arbiter: RTL and testbench

Four-port round-robin arbiter that shares the single SRAM controller port in the memory manager between the GPU's memory clients: display scan-out, rasterizer pixel writes, texture fetch, and host access. It latches one client request at a time, drives it to the SRAM controller with a hold-until-done handshake, and returns a one-cycle acknowledge (with read data) to the winning client. At most one SRAM transaction is outstanding.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: four-port round-robin arbiter in front of the single SRAM
// controller port. One transaction is outstanding at a time; the winner gets
// a one-cycle acknowledge (with read data for reads).
//
// Optional build macro: MEM_ARB_DISPLAY_PRIO_EN gives port 0 (display
// scan-out) absolute priority. Ports 1-3 stay round-robin among themselves.
// Without the macro, all four ports are served pure round-robin.
//
// Handshake: a client raises iReqValid[k] with write/addr/data and holds them
// stable until oReqAck[k] pulses. Toward the controller, oMemValid and the
// oMem* payload are held stable until iMemDone pulses. iMemDone is only
// honoured in ISSUE. Withdrawing iReqValid after the grant has no effect.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic [NUM_PORTS-1:0]        iReqValid,
    input  logic [NUM_PORTS-1:0]        iReqWrite,
    input  logic [NUM_PORTS*ADDR_W-1:0] iReqAddr,
    input  logic [NUM_PORTS*DATA_W-1:0] iReqData,
    output logic [NUM_PORTS-1:0]        oReqAck,
    output logic [DATA_W-1:0]           oRdData,
    output logic                        oMemValid,
    output logic                        oMemWrite,
    output logic [ADDR_W-1:0]           oMemAddr,
    output logic [DATA_W-1:0]           oMemData,
    input  logic                        iMemDone,
    input  logic [DATA_W-1:0]           iMemData,
    output logic                        oBusy,
    output logic [1:0]                  oGrantId,
    output logic [1:0]                  oDbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [1:0]          ptr, ptr_n;
    logic [1:0]          win;
    logic                win_upd_ptr;
    logic [1:0]          grant_n;
    logic                mem_valid_n;
    logic                mem_write_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_data_n;
    logic [NUM_PORTS-1:0] ack_n;
    logic [DATA_W-1:0]   rd_n;

    // Arbitration: first valid port searching upward from the port after the
    // last grant; scanning from the far end lets the nearest hit win.
    always_comb begin
        win         = ptr;
        win_upd_ptr = 1'b1;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (iReqValid[ptr + 2'(i)]) begin
                win = ptr + 2'(i);
            end
        end
`ifdef MEM_ARB_DISPLAY_PRIO_EN
        // Display always wins and does not disturb the rotation of 1-3.
        if (iReqValid[0]) begin
            win         = 2'd0;
            win_upd_ptr = 1'b0;
        end
`endif
    end

    // Next-state and next-output logic; every output is a register.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        grant_n     = oGrantId;
        mem_valid_n = oMemValid;
        mem_write_n = oMemWrite;
        mem_addr_n  = oMemAddr;
        mem_data_n  = oMemData;
        ack_n       = '0;
        rd_n        = oRdData;
        case (state)
            IDLE: begin
                if (|iReqValid) begin
                    mem_valid_n = 1'b1;
                    mem_write_n = iReqWrite[win];
                    mem_addr_n  = iReqAddr[int'(win)*ADDR_W +: ADDR_W];
                    mem_data_n  = iReqData[int'(win)*DATA_W +: DATA_W];
                    grant_n     = win;
                    if (win_upd_ptr) begin
                        ptr_n = win;
                    end
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (iMemDone) begin
                    mem_valid_n = 1'b0;
                    if (!oMemWrite) begin
                        rd_n = iMemData;
                    end
                    ack_n[oGrantId] = 1'b1;
                    state_n         = RESP;
                end
            end
            RESP: begin
                // Dead cycle: lets the client renew its request and the
                // controller drop iMemDone before the next arbitration.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset drops any
    // in-flight transaction without acknowledging it.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            oGrantId  <= 2'd0;
            oMemValid <= 1'b0;
            oMemWrite <= 1'b0;
            oMemAddr  <= '0;
            oMemData  <= '0;
            oReqAck   <= '0;
            oRdData   <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            oGrantId  <= grant_n;
            oMemValid <= mem_valid_n;
            oMemWrite <= mem_write_n;
            oMemAddr  <= mem_addr_n;
            oMemData  <= mem_data_n;
            oReqAck   <= ack_n;
            oRdData   <= rd_n;
        end
    end

    assign oBusy     = (state != IDLE);
    assign oDbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter. A simple
// SRAM responder answers oMemValid after a programmable delay; expected
// grants come from a round-robin rule model and read data from a shadow
// memory updated in acknowledge order.
`timescale 1ns/1ps

module tb_mem_arbiter;

    // ---------------- clock / reset / DUT ----------------
    logic        iClock    = 1'b0;
    logic        iReset    = 1'b1;
    logic [3:0]  iReqValid = '0;
    logic [3:0]  iReqWrite = '0;
    logic [87:0] iReqAddr  = '0;
    logic [63:0] iReqData  = '0;
    logic [3:0]  oReqAck;
    logic [15:0] oRdData;
    logic        oMemValid;
    logic        oMemWrite;
    logic [21:0] oMemAddr;
    logic [15:0] oMemData;
    logic        iMemDone  = 1'b0;
    logic [15:0] iMemData  = '0;
    logic        oBusy;
    logic [1:0]  oGrantId;
    logic [1:0]  oDbgState;

    always #5 iClock = ~iClock;

    mem_arbiter dut (
        .iClock(iClock), .iReset(iReset),
        .iReqValid(iReqValid), .iReqWrite(iReqWrite),
        .iReqAddr(iReqAddr), .iReqData(iReqData),
        .oReqAck(oReqAck), .oRdData(oRdData),
        .oMemValid(oMemValid), .oMemWrite(oMemWrite),
        .oMemAddr(oMemAddr), .oMemData(oMemData),
        .iMemDone(iMemDone), .iMemData(iMemData),
        .oBusy(oBusy), .oGrantId(oGrantId), .oDbgState(oDbgState)
    );

    // ---------------- bench state ----------------
    int          checks = 0;
    int          errors = 0;
    int          mem_delay = 0;
    bit          stray_req = 1'b0;
    logic [15:0] sram[logic [21:0]];
    logic [15:0] ref_mem[logic [21:0]];
    int          model_last = 3;
    logic [1:0]  exp_q[$];
    logic        pend_w[4];
    logic [21:0] pend_a[4];
    logic [15:0] pend_d[4];

    function automatic logic [15:0] init_val(input logic [21:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] sram_rd(input logic [21:0] a);
        return sram.exists(a) ? sram[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [21:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Rule model: first requesting port after the last winner, wrapping.
    function automatic int model_pick(input logic [3:0] v, input int last);
`ifdef MEM_ARB_DISPLAY_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int i = 1; i <= 4; i++) begin
            if (v[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic int model_next(input int w, input int last);
`ifdef MEM_ARB_DISPLAY_PRIO_EN
        if (w == 0) return last;
`endif
        return w;
    endfunction

    // ---------------- SRAM responder ----------------
    initial begin : sram_responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge iClock); #1;
            iMemDone = 1'b0;
            if (stray_req) begin
                stray_req = 1'b0;
                iMemDone  = 1'b1;
                iMemData  = 16'hDEAD;
            end else if (oMemValid) begin
                if (cnt >= mem_delay) begin
                    if (oMemWrite) sram[oMemAddr] = oMemData;
                    else           iMemData = sram_rd(oMemAddr);
                    iMemDone = 1'b1;
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic w, input logic [21:0] a, input logic [15:0] d);
        iReqValid[p]        = 1'b1;
        iReqWrite[p]        = w;
        iReqAddr[p*22 +: 22] = a;
        iReqData[p*16 +: 16] = d;
    endtask

    task automatic do_reset();
        iReset    = 1'b1;
        iReqValid = '0;
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        iReset     = 1'b0;
        model_last = 3;
        exp_q.delete();
    endtask

    // Single transaction on an otherwise idle arbiter; returns observations.
    task automatic run_txn(input int p, input logic w, input logic [21:0] a, input logic [15:0] d,
                           output logic [1:0] gid, output logic gw, output logic [21:0] ga,
                           output logic [3:0] ack, output logic [15:0] rd, output int lat);
        set_req(p, w, a, d);
        lat = 0; ack = '0; gid = '0; gw = 1'b0; ga = '0; rd = '0;
        while (ack == 4'b0 && lat < 100) begin
            @(posedge iClock); #1;
            lat++;
            if (lat == 1) begin
                gid = oGrantId; gw = oMemWrite; ga = oMemAddr;
            end
            ack = oReqAck;
            rd  = oRdData;
        end
        iReqValid[p] = 1'b0;
        @(posedge iClock); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iReset    = 1'b1;
        iReqValid = 4'hF;
        repeat (3) begin @(posedge iClock); #1; end
        checks++; if (oMemValid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0h expected 0", oMemValid); end
        checks++; if (oReqAck !== 4'h0) begin errors++; $display("FAIL reset_ack: got %0h expected 0", oReqAck); end
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", oBusy); end
        checks++; if (oGrantId !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0h expected 0", oGrantId); end
        checks++; if (oMemAddr !== 22'h0 || oMemData !== 16'h0 || oMemWrite !== 1'b0) begin
            errors++; $display("FAIL reset_mem_bus: got addr %0h data %0h wr %0h expected 0 0 0", oMemAddr, oMemData, oMemWrite);
        end
        checks++; if (oRdData !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", oRdData); end
        iReqValid  = '0;
        iReset     = 1'b0;
        model_last = 3;
        @(posedge iClock); #1;
    endtask

    task automatic test_single_read();
        int exp_g;
        sram[22'h12]    = 16'hBEEF;
        ref_mem[22'h12] = 16'hBEEF;
        mem_delay = 0;
        exp_g = model_pick(4'b0100, model_last);
        set_req(2, 1'b0, 22'h12, 16'h0);
        @(posedge iClock); #1;
        checks++; if (oMemValid !== 1'b1) begin errors++; $display("FAIL single_mem_valid: got %0h expected 1", oMemValid); end
        checks++; if (oGrantId !== 2'(exp_g)) begin errors++; $display("FAIL single_grant: got %0d expected %0d", oGrantId, exp_g); end
        checks++; if (oMemAddr !== 22'h12 || oMemWrite !== 1'b0) begin
            errors++; $display("FAIL single_mem_bus: got addr %0h wr %0h expected 12 0", oMemAddr, oMemWrite);
        end
        checks++; if (oBusy !== 1'b1 || oReqAck !== 4'h0) begin errors++; $display("FAIL single_busy: got busy %0h ack %0h expected 1 0", oBusy, oReqAck); end
        model_last = model_next(exp_g, model_last);
        @(posedge iClock); #1;
        checks++; if (oReqAck !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", oReqAck); end
        checks++; if (oRdData !== ref_rd(22'h12)) begin errors++; $display("FAIL single_rd_data: got %0h expected %0h", oRdData, ref_rd(22'h12)); end
        checks++; if (oMemValid !== 1'b0) begin errors++; $display("FAIL single_mem_drop: got %0h expected 0", oMemValid); end
        iReqValid[2] = 1'b0;
        @(posedge iClock); #1;
        checks++; if (oReqAck !== 4'h0 || oBusy !== 1'b0) begin errors++; $display("FAIL single_idle: got ack %0h busy %0h expected 0 0", oReqAck, oBusy); end
    endtask

    task automatic test_write_read();
        logic [1:0] gid; logic gw; logic [21:0] ga; logic [3:0] ack; logic [15:0] rd; int lat;
        run_txn(1, 1'b1, 22'h3FFFFF, 16'h1234, gid, gw, ga, ack, rd, lat);
        model_last = model_next(1, model_last);
        ref_mem[22'h3FFFFF] = 16'h1234;
        checks++; if (gid !== 2'd1 || gw !== 1'b1) begin errors++; $display("FAIL wr_grant: got id %0d wr %0h expected 1 1", gid, gw); end
        checks++; if (ga !== 22'h3FFFFF) begin errors++; $display("FAIL wr_addr: got %0h expected 3fffff", ga); end
        checks++; if (ack !== 4'b0010 || lat != 2) begin errors++; $display("FAIL wr_ack: got %b at %0d expected 0010 at 2", ack, lat); end
        run_txn(1, 1'b0, 22'h3FFFFF, 16'h0, gid, gw, ga, ack, rd, lat);
        model_last = model_next(1, model_last);
        checks++; if (gw !== 1'b0 || ga !== 22'h3FFFFF) begin errors++; $display("FAIL rd_bus: got wr %0h addr %0h expected 0 3fffff", gw, ga); end
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rd_ack: got %b expected 0010", ack); end
        checks++; if (rd !== ref_rd(22'h3FFFFF)) begin errors++; $display("FAIL rd_data: got %0h expected %0h", rd, ref_rd(22'h3FFFFF)); end
    endtask

    // Ports in mask request continuously; port 0 drops after drop0_after acks.
    task automatic test_contention(input string name, input logic [3:0] mask, input int n_acks, input int drop0_after);
        int acks, acks0, cyc, last_cyc, w;
        logic prev_mv;
        logic [3:0] v_edge;
        logic [1:0] g;
        do_reset();
        mem_delay = 0;
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) begin
                pend_w[p] = 1'b0; pend_a[p] = 22'($urandom_range(0, 63)); pend_d[p] = '0;
                set_req(p, pend_w[p], pend_a[p], pend_d[p]);
            end
        end
        acks = 0; acks0 = 0; cyc = 0; last_cyc = -1; prev_mv = 1'b0;
        while (acks < n_acks && cyc < 200) begin
            v_edge = iReqValid;
            @(posedge iClock); #1;
            cyc++;
            if (oMemValid && !prev_mv) begin
                w = model_pick(v_edge, model_last);
                checks++;
                if (w < 0 || oGrantId !== 2'(w)) begin errors++; $display("FAIL %s_grant: got %0d expected %0d", name, oGrantId, w); end
                if (w >= 0) begin exp_q.push_back(2'(w)); model_last = model_next(w, model_last); end
            end
            if (oReqAck !== 4'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s_ack_unexpected: got %b expected 0000", name, oReqAck);
                end else begin
                    g = exp_q.pop_front();
                    if (oReqAck !== (4'(1) << g)) begin errors++; $display("FAIL %s_ack: got %b expected %b", name, oReqAck, 4'(1) << g); end
                    checks++;
                    if (oRdData !== ref_rd(pend_a[g])) begin errors++; $display("FAIL %s_rd_data: got %0h expected %0h", name, oRdData, ref_rd(pend_a[g])); end
                    if (last_cyc >= 0) begin
                        checks++;
                        if (cyc - last_cyc != 3) begin errors++; $display("FAIL %s_spacing: got %0d expected 3", name, cyc - last_cyc); end
                    end
                    last_cyc = cyc;
                    acks++;
                    if (g == 2'd0) acks0++;
                    if (g == 2'd0 && acks0 == drop0_after) begin
                        iReqValid[0] = 1'b0;
                    end else begin
                        pend_a[g] = 22'($urandom_range(0, 63));
                        set_req(int'(g), 1'b0, pend_a[g], 16'h0);
                    end
                end
            end
            prev_mv = oMemValid;
        end
        checks++; if (acks != n_acks) begin errors++; $display("FAIL %s_timeout: got %0d acks expected %0d", name, acks, n_acks); end
        iReqValid = '0;
        repeat (3) begin @(posedge iClock); #1; end
    endtask

    task automatic test_delay();
        int acks, ack_cyc;
        logic [21:0] a0;
        logic w0;
        do_reset();
        mem_delay = 5;
        acks = 0; ack_cyc = 0; a0 = '0; w0 = 1'b0;
        set_req(3, 1'b0, 22'h7, 16'h0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge iClock); #1;
            if (c == 1) begin
                a0 = oMemAddr; w0 = oMemWrite;
                checks++;
                if (oMemValid !== 1'b1 || oGrantId !== 2'd3 || a0 !== 22'h7) begin
                    errors++; $display("FAIL delay_grant: got valid %0h id %0d addr %0h expected 1 3 7", oMemValid, oGrantId, a0);
                end
            end else if (acks == 0 && oReqAck === 4'h0) begin
                checks++;
                if (oMemValid !== 1'b1 || oMemAddr !== a0 || oMemWrite !== w0) begin
                    errors++; $display("FAIL delay_hold: got valid %0h addr %0h at cycle %0d expected 1 %0h", oMemValid, oMemAddr, c, a0);
                end
            end
            if (oReqAck !== 4'h0) begin
                acks++; ack_cyc = c;
                checks++;
                if (oReqAck !== 4'b1000 || oRdData !== ref_rd(22'h7)) begin
                    errors++; $display("FAIL delay_ack: got %b data %0h expected 1000 %0h", oReqAck, oRdData, ref_rd(22'h7));
                end
                iReqValid[3] = 1'b0;
            end
        end
        model_last = model_next(3, model_last);
        checks++; if (acks != 1) begin errors++; $display("FAIL delay_ack_count: got %0d expected 1", acks); end
        checks++; if (ack_cyc != 2 + 5) begin errors++; $display("FAIL delay_latency: got %0d expected %0d", ack_cyc, 2 + 5); end
        mem_delay = 0;
        stray_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge iClock); #1;
            checks++;
            if (oReqAck !== 4'h0 || oMemValid !== 1'b0) begin errors++; $display("FAIL stray_done: got ack %b valid %0h expected 0000 0", oReqAck, oMemValid); end
        end
        checks++; if (oRdData !== ref_rd(22'h7)) begin errors++; $display("FAIL stray_rd_data: got %0h expected %0h", oRdData, ref_rd(22'h7)); end
    endtask

    task automatic test_reset_mid_issue();
        int exp_g;
        logic seen_ack;
        do_reset();
        mem_delay = 20;
        set_req(2, 1'b1, 22'h5, 16'h5555);
        @(posedge iClock); #1;
        checks++; if (oMemValid !== 1'b1) begin errors++; $display("FAIL midreset_issue: got %0h expected 1", oMemValid); end
        iReset = 1'b1;
        @(posedge iClock); #1;
        checks++; if (oMemValid !== 1'b0 || oReqAck !== 4'h0) begin errors++; $display("FAIL midreset_outputs: got valid %0h ack %b expected 0 0000", oMemValid, oReqAck); end
        checks++; if (oBusy !== 1'b0 || oGrantId !== 2'd0) begin errors++; $display("FAIL midreset_state: got busy %0h id %0d expected 0 0", oBusy, oGrantId); end
        iReset = 1'b0; iReqValid = '0; model_last = 3; mem_delay = 0;
        seen_ack = 1'b0;
        repeat (25) begin @(posedge iClock); #1; if (oReqAck !== 4'h0) seen_ack = 1'b1; end
        checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL midreset_dropped_ack: got 1 expected 0"); end
        // After reset port 0 must win against port 2.
        set_req(0, 1'b0, 22'h5, 16'h0);
        set_req(2, 1'b0, 22'h9, 16'h0);
        exp_g = model_pick(4'b0101, model_last);
        @(posedge iClock); #1;
        checks++; if (oGrantId !== 2'(exp_g) || oMemValid !== 1'b1) begin errors++; $display("FAIL midreset_first: got %0d expected %0d", oGrantId, exp_g); end
        model_last = model_next(exp_g, model_last);
        @(posedge iClock); #1;
        checks++; if (oReqAck !== 4'b0001 || oRdData !== ref_rd(22'h5)) begin
            errors++; $display("FAIL midreset_ack0: got %b data %0h expected 0001 %0h", oReqAck, oRdData, ref_rd(22'h5));
        end
        iReqValid[0] = 1'b0;
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        exp_g = model_pick(4'b0100, model_last);
        checks++; if (oGrantId !== 2'(exp_g) || oMemValid !== 1'b1) begin errors++; $display("FAIL midreset_second: got %0d expected %0d", oGrantId, exp_g); end
        model_last = model_next(exp_g, model_last);
        @(posedge iClock); #1;
        checks++; if (oReqAck !== 4'b0100) begin errors++; $display("FAIL midreset_ack2: got %b expected 0100", oReqAck); end
        iReqValid[2] = 1'b0;
        repeat (2) begin @(posedge iClock); #1; end
    endtask

    task automatic test_random();
        int remaining[4];
        int target, done_cnt, cyc, w;
        logic prev_mv;
        logic [3:0] v_edge;
        logic [1:0] g;
        do_reset();
        target = 0; done_cnt = 0; cyc = 0; prev_mv = 1'b0;
        for (int p = 0; p < 4; p++) begin
            remaining[p] = $urandom_range(4, 8);
            target += remaining[p];
            pend_w[p] = 1'($urandom_range(0, 1));
            pend_a[p] = ($urandom_range(0, 9) == 0) ? 22'h3FFFFF : 22'($urandom_range(0, 15));
            pend_d[p] = 16'($urandom);
            set_req(p, pend_w[p], pend_a[p], pend_d[p]);
        end
        while (done_cnt < target && cyc < 3000) begin
            v_edge    = iReqValid;
            mem_delay = $urandom_range(0, 2);
            @(posedge iClock); #1;
            cyc++;
            if (oMemValid && !prev_mv) begin
                w = model_pick(v_edge, model_last);
                checks++;
                if (w < 0 || oGrantId !== 2'(w)) begin
                    errors++; $display("FAIL random_grant: got %0d expected %0d", oGrantId, w);
                end else begin
                    checks++;
                    if (oMemAddr !== pend_a[w] || oMemWrite !== pend_w[w] || (pend_w[w] && oMemData !== pend_d[w])) begin
                        errors++; $display("FAIL random_payload: got addr %0h wr %0h expected %0h %0h", oMemAddr, oMemWrite, pend_a[w], pend_w[w]);
                    end
                    exp_q.push_back(2'(w));
                    model_last = model_next(w, model_last);
                end
            end
            if (oReqAck !== 4'h0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL random_ack_unexpected: got %b expected 0000", oReqAck);
                end else begin
                    g = exp_q.pop_front();
                    if (oReqAck !== (4'(1) << g)) begin errors++; $display("FAIL random_ack: got %b expected %b", oReqAck, 4'(1) << g); end
                    if (pend_w[g]) begin
                        ref_mem[pend_a[g]] = pend_d[g];
                    end else begin
                        checks++;
                        if (oRdData !== ref_rd(pend_a[g])) begin errors++; $display("FAIL random_rd_data: got %0h expected %0h", oRdData, ref_rd(pend_a[g])); end
                    end
                    done_cnt++;
                    remaining[g]--;
                    if (remaining[g] > 0) begin
                        pend_w[g] = 1'($urandom_range(0, 1));
                        pend_a[g] = ($urandom_range(0, 9) == 0) ? 22'h3FFFFF : 22'($urandom_range(0, 15));
                        pend_d[g] = 16'($urandom);
                        set_req(int'(g), pend_w[g], pend_a[g], pend_d[g]);
                    end else begin
                        iReqValid[g] = 1'b0;
                    end
                end
            end
            prev_mv = oMemValid;
        end
        checks++; if (done_cnt != target) begin errors++; $display("FAIL random_timeout: got %0d acks expected %0d", done_cnt, target); end
        iReqValid = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention("round_robin", 4'hF, 5, 0);
        test_contention("two_ports", 4'b1001, 6, 3);
        test_delay();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
